// File: rtl/ibex_pkg.sv
// Shared types for the load/store path: access sizes and controller states.
// Also holds the small decode helpers used by the LSU controller.
package ibex_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_WAIT_GNT1,
        LS_WAIT_RVALID1,
        LS_WAIT_GNT2,
        LS_WAIT_RVALID2
    } ls_fsm_e;

    function automatic logic lsu_is_split(
        input lsu_type_e  t,
        input logic [1:0] off
    );
        unique case (1'b1)
            (t == LSU_WORD): lsu_is_split = (off != 2'b00);
            (t == LSU_HALF): lsu_is_split = (off == 2'b11);
            default:         lsu_is_split = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be_mask(input lsu_type_e t);
        unique case (1'b1)
            (t == LSU_WORD): lsu_be_mask = 4'b1111;
            (t == LSU_HALF): lsu_be_mask = 4'b0011;
            default:         lsu_be_mask = 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/ibex_load_data_align.sv
// Load data alignment: merges the two halves of a split access, picks the
// addressed byte/half/word and sign- or zero-extends it.
module ibex_load_data_align
    import ibex_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [23:0] rdata_hold_i,
    input  logic [1:0]  off_i,
    input  lsu_type_e   type_i,
    input  logic        sign_ext_i,
    input  logic        split_i,
    output logic [31:0] rdata_o
);

    logic [31:0] raw;

    // Split: window over {second word, upper 3 bytes of first word}
    always_comb begin
        raw = rdata_i;
        unique case (off_i)
            2'd1: raw = split_i ? {rdata_i[7:0], rdata_hold_i}
                                : {8'h00, rdata_i[31:8]};
            2'd2: raw = split_i ? {rdata_i[15:0], rdata_hold_i[23:8]}
                                : {16'h0000, rdata_i[31:16]};
            2'd3: raw = split_i ? {rdata_i[23:0], rdata_hold_i[23:16]}
                                : {24'h000000, rdata_i[31:24]};
            default: raw = rdata_i;
        endcase
    end

    always_comb begin
        unique case (type_i)
            LSU_BYTE: rdata_o = {{24{sign_ext_i & raw[7]}}, raw[7:0]};
            LSU_HALF: rdata_o = {{16{sign_ext_i & raw[15]}}, raw[15:0]};
            default:  rdata_o = raw;
        endcase
    end

endmodule

// File: rtl/ibex_load_store_ctrl.sv
// Load/store controller: issues one ID/EX memory request at a time on the
// data bus, splitting misaligned accesses into two word transactions.
module ibex_load_store_ctrl
    import ibex_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_req_done_o,
    output logic        busy_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,

    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o
);

    ls_fsm_e     state_q, state_d;

    logic        we_q;
    lsu_type_e   type_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [23:0] rdata_hold_q;

    logic        idle;
    logic        capture;
    logic        hold_en;
    logic        cur_we;
    lsu_type_e   cur_type;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [1:0]  off;
    logic        split;
    logic [7:0]  be_full;
    logic [31:0] wdata_rot;
    logic [31:0] addr_word;
    logic        part2;
    logic        resp_valid;
    logic [31:0] load_data;

    assign idle    = (state_q == LS_IDLE);
    assign capture = idle & lsu_req_i;
    assign hold_en = (state_q == LS_WAIT_RVALID1) & data_rvalid_i
                   & ~data_err_i & split;

    // In IDLE the bus is driven straight from ID/EX, afterwards from registers
    assign cur_we    = idle ? lsu_we_i : we_q;
    assign cur_type  = idle ? lsu_type_e'(lsu_type_i) : type_q;
    assign cur_addr  = idle ? lsu_addr_i : addr_q;
    assign cur_wdata = idle ? lsu_wdata_i : wdata_q;

    assign off      = cur_addr[1:0];
    assign split    = lsu_is_split(cur_type, off);
    assign be_full  = {4'b0000, lsu_be_mask(cur_type)} << off;
    assign addr_word = {cur_addr[31:2], 2'b00};

    always_comb begin
        unique case (off)
            2'd1:    wdata_rot = {cur_wdata[23:0], cur_wdata[31:24]};
            2'd2:    wdata_rot = {cur_wdata[15:0], cur_wdata[31:16]};
            2'd3:    wdata_rot = {cur_wdata[7:0], cur_wdata[31:8]};
            default: wdata_rot = cur_wdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LS_IDLE: begin
                if (lsu_req_i) begin
                    state_d = data_gnt_i ? LS_WAIT_RVALID1 : LS_WAIT_GNT1;
                end
            end
            LS_WAIT_GNT1: begin
                if (data_gnt_i) state_d = LS_WAIT_RVALID1;
            end
            LS_WAIT_RVALID1: begin
                if (data_rvalid_i) begin
                    state_d = (data_err_i || !split) ? LS_IDLE : LS_WAIT_GNT2;
                end
            end
            LS_WAIT_GNT2: begin
                if (data_gnt_i) state_d = LS_WAIT_RVALID2;
            end
            LS_WAIT_RVALID2: begin
                if (data_rvalid_i) state_d = LS_IDLE;
            end
            default: state_d = LS_IDLE;
        endcase
    end

    always_comb begin
        data_req_o     = 1'b0;
        part2          = 1'b0;
        lsu_req_done_o = 1'b0;
        resp_valid     = 1'b0;
        unique case (state_q)
            LS_IDLE: begin
                data_req_o     = lsu_req_i;
                lsu_req_done_o = lsu_req_i & data_gnt_i & ~split;
            end
            LS_WAIT_GNT1: begin
                data_req_o     = 1'b1;
                lsu_req_done_o = data_gnt_i & ~split;
            end
            LS_WAIT_RVALID1: begin
                resp_valid     = data_rvalid_i & (data_err_i | ~split);
                lsu_req_done_o = data_rvalid_i & data_err_i & split;
            end
            LS_WAIT_GNT2: begin
                data_req_o     = 1'b1;
                part2          = 1'b1;
                lsu_req_done_o = data_gnt_i;
            end
            LS_WAIT_RVALID2: begin
                resp_valid = data_rvalid_i;
            end
            default: ;
        endcase
    end

    assign busy_o       = ~idle;
    assign data_addr_o  = data_req_o ? (part2 ? addr_word + 32'd4 : addr_word)
                                     : 32'h0;
    assign data_we_o    = data_req_o & cur_we;
    assign data_be_o    = data_req_o ? (part2 ? be_full[7:4] : be_full[3:0])
                                     : 4'b0000;
    assign data_wdata_o = data_req_o ? wdata_rot : 32'h0;

    assign lsu_resp_valid_o = resp_valid;
    assign lsu_resp_err_o   = resp_valid & data_err_i;
    assign rf_we_lsu_o      = resp_valid & ~we_q & ~data_err_i;
    assign rf_wdata_lsu_o   = rf_we_lsu_o ? load_data : 32'h0;

    ibex_load_data_align u_align (
        .rdata_i      (data_rdata_i),
        .rdata_hold_i (rdata_hold_q),
        .off_i        (addr_q[1:0]),
        .type_i       (type_q),
        .sign_ext_i   (sign_q),
        .split_i      (state_q == LS_WAIT_RVALID2),
        .rdata_o      (load_data)
    );

    generate
        if (ResetAll) begin : g_dp_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    we_q         <= 1'b0;
                    type_q       <= LSU_WORD;
                    sign_q       <= 1'b0;
                    addr_q       <= 32'h0;
                    wdata_q      <= 32'h0;
                    rdata_hold_q <= 24'h0;
                end else begin
                    if (capture) begin
                        we_q    <= lsu_we_i;
                        type_q  <= lsu_type_e'(lsu_type_i);
                        sign_q  <= lsu_sign_ext_i;
                        addr_q  <= lsu_addr_i;
                        wdata_q <= lsu_wdata_i;
                    end
                    if (hold_en) rdata_hold_q <= data_rdata_i[31:8];
                end
            end
        end else begin : g_dp_norst
            always_ff @(posedge clk_i) begin
                if (capture) begin
                    we_q    <= lsu_we_i;
                    type_q  <= lsu_type_e'(lsu_type_i);
                    sign_q  <= lsu_sign_ext_i;
                    addr_q  <= lsu_addr_i;
                    wdata_q <= lsu_wdata_i;
                end
                if (hold_en) rdata_hold_q <= data_rdata_i[31:8];
            end
        end
    endgenerate

endmodule

// File: tb/tb_ibex_load_store_ctrl.sv
// Directed bench for the load/store controller with hand-computed vectors.
module tb_ibex_load_store_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [1:0]  lsu_type = 2'b00;
    logic        lsu_sign = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        req_done;
    logic        busy;
    logic        d_req;
    logic        d_gnt = 1'b0;
    logic        d_rvalid = 1'b0;
    logic        d_err = 1'b0;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata = '0;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic        resp_valid;
    logic        resp_err;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ibex_load_store_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .lsu_req_i        (lsu_req),
        .lsu_we_i         (lsu_we),
        .lsu_type_i       (lsu_type),
        .lsu_sign_ext_i   (lsu_sign),
        .lsu_addr_i       (lsu_addr),
        .lsu_wdata_i      (lsu_wdata),
        .lsu_req_done_o   (req_done),
        .busy_o           (busy),
        .data_req_o       (d_req),
        .data_gnt_i       (d_gnt),
        .data_rvalid_i    (d_rvalid),
        .data_err_i       (d_err),
        .data_addr_o      (d_addr),
        .data_we_o        (d_we),
        .data_be_o        (d_be),
        .data_wdata_o     (d_wdata),
        .data_rdata_i     (d_rdata),
        .rf_wdata_lsu_o   (rf_wdata),
        .rf_we_lsu_o      (rf_we),
        .lsu_resp_valid_o (resp_valid),
        .lsu_resp_err_o   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs change 1ns after the edge
    task automatic nxt();
        @(posedge clk);
        #1;
        lsu_req  = 1'b0;
        d_gnt    = 1'b0;
        d_rvalid = 1'b0;
        d_err    = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] t, input logic s,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic g);
        lsu_req   = 1'b1;
        lsu_we    = we;
        lsu_type  = t;
        lsu_sign  = s;
        lsu_addr  = a;
        lsu_wdata = w;
        d_gnt     = g;
    endtask

    task automatic lh_split(input logic s, input logic [31:0] exp);
        issue(1'b0, 2'b01, s, 32'h1003, 32'h0, 1'b1);
        #1;
        chk("lh_be1", {28'h0, d_be}, 32'h8);
        chk("lh_done1", {31'h0, req_done}, 32'h0);
        nxt();
        d_rvalid = 1'b1;
        d_rdata  = 32'h80123456;
        #1;
        chk("lh_rv1_resp", {31'h0, resp_valid}, 32'h0);
        nxt();
        d_gnt = 1'b1;
        #1;
        chk("lh_addr2", d_addr, 32'h1004);
        chk("lh_be2", {28'h0, d_be}, 32'h1);
        chk("lh_done2", {31'h0, req_done}, 32'h1);
        nxt();
        d_rvalid = 1'b1;
        d_rdata  = 32'h123456FF;
        #1;
        chk("lh_data", rf_wdata, exp);
        chk("lh_we", {31'h0, rf_we}, 32'h1);
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_req", {31'h0, d_req}, 32'h0);
        chk("rst_resp", {31'h0, resp_valid}, 32'h0);
        chk("rst_rfwe", {31'h0, rf_we}, 32'h0);
        chk("rst_addr", d_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();

        // aligned LW, grant in the request cycle
        issue(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 1'b1);
        #1;
        chk("lw_req", {31'h0, d_req}, 32'h1);
        chk("lw_addr", d_addr, 32'h1000);
        chk("lw_be", {28'h0, d_be}, 32'hF);
        chk("lw_done", {31'h0, req_done}, 32'h1);
        nxt();
        chk("lw_busy", {31'h0, busy}, 32'h1);
        nxt();
        d_rvalid = 1'b1;
        d_rdata  = 32'hDEADBEEF;
        #1;
        chk("lw_resp", {31'h0, resp_valid}, 32'h1);
        chk("lw_data", rf_wdata, 32'hDEADBEEF);
        chk("lw_we", {31'h0, rf_we}, 32'h1);
        nxt();
        chk("lw_idle", {31'h0, busy}, 32'h0);

        // misaligned LW at 0x1002
        issue(1'b0, 2'b00, 1'b0, 32'h1002, 32'h0, 1'b1);
        #1;
        chk("mlw_addr1", d_addr, 32'h1000);
        chk("mlw_be1", {28'h0, d_be}, 32'hC);
        chk("mlw_done1", {31'h0, req_done}, 32'h0);
        nxt();
        d_rvalid = 1'b1;
        d_rdata  = 32'h44332211;
        #1;
        chk("mlw_rv1", {31'h0, resp_valid}, 32'h0);
        nxt();
        #1;
        chk("mlw_req2", {31'h0, d_req}, 32'h1);
        chk("mlw_addr2", d_addr, 32'h1004);
        chk("mlw_be2", {28'h0, d_be}, 32'h3);
        chk("mlw_nodone", {31'h0, req_done}, 32'h0);
        d_gnt = 1'b1;
        #1;
        chk("mlw_done2", {31'h0, req_done}, 32'h1);
        nxt();
        d_rvalid = 1'b1;
        d_rdata  = 32'h88776655;
        #1;
        chk("mlw_data", rf_wdata, 32'h66554433);
        chk("mlw_we", {31'h0, rf_we}, 32'h1);
        nxt();

        lh_split(1'b1, 32'hFFFFFF80);
        lh_split(1'b0, 32'h0000FF80);

        // SB with delayed grant; busy-time request and stray rvalid ignored
        issue(1'b1, 2'b10, 1'b0, 32'h2001, 32'h000000A5, 1'b0);
        #1;
        chk("sb_req0", {31'h0, d_req}, 32'h1);
        chk("sb_wdata0", d_wdata, 32'h0000A500);
        chk("sb_be0", {28'h0, d_be}, 32'h2);
        chk("sb_we0", {31'h0, d_we}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            nxt();
            lsu_req   = 1'b1;
            lsu_addr  = 32'h5557;
            lsu_wdata = 32'h12345678;
            lsu_we    = 1'b0;
            d_rvalid  = 1'b1;
            d_gnt     = (i == 3);
            #1;
            chk("sb_req", {31'h0, d_req}, 32'h1);
            chk("sb_addr", d_addr, 32'h2000);
            chk("sb_wdata", d_wdata, 32'h0000A500);
            chk("sb_be", {28'h0, d_be}, 32'h2);
            chk("sb_stray", {31'h0, resp_valid}, 32'h0);
            chk("sb_done", {31'h0, req_done}, (i == 3) ? 32'h1 : 32'h0);
        end
        nxt();
        d_rvalid = 1'b1;
        #1;
        chk("sb_resp", {31'h0, resp_valid}, 32'h1);
        chk("sb_rfwe", {31'h0, rf_we}, 32'h0);
        nxt();
        chk("sb_idle", {31'h0, busy}, 32'h0);

        // split LW with error on first response
        issue(1'b0, 2'b00, 1'b0, 32'h3001, 32'h0, 1'b1);
        nxt();
        d_rvalid = 1'b1;
        d_err    = 1'b1;
        #1;
        chk("err_resp", {31'h0, resp_valid}, 32'h1);
        chk("err_err", {31'h0, resp_err}, 32'h1);
        chk("err_done", {31'h0, req_done}, 32'h1);
        chk("err_rfwe", {31'h0, rf_we}, 32'h0);
        nxt();
        chk("err_noreq", {31'h0, d_req}, 32'h0);
        chk("err_idle", {31'h0, busy}, 32'h0);

        // split word wrapping past the top of the address space
        issue(1'b0, 2'b00, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b1);
        nxt();
        d_rvalid = 1'b1;
        d_rdata  = 32'hBBAA0000;
        nxt();
        d_gnt = 1'b1;
        #1;
        chk("wrap_addr2", d_addr, 32'h0);
        nxt();
        d_rvalid = 1'b1;
        d_rdata  = 32'h0000DDCC;
        #1;
        chk("wrap_data", rf_wdata, 32'hDDCCBBAA);
        nxt();

        // reset during WAIT_RVALID1, then a late rvalid
        issue(1'b0, 2'b00, 1'b0, 32'h4000, 32'h0, 1'b1);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("ra_busy", {31'h0, busy}, 32'h0);
        chk("ra_req", {31'h0, d_req}, 32'h0);
        chk("ra_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();
        d_rvalid = 1'b1;
        d_rdata  = 32'hCAFEF00D;
        #1;
        chk("ra_stray_resp", {31'h0, resp_valid}, 32'h0);
        chk("ra_stray_we", {31'h0, rf_we}, 32'h0);
        chk("ra_stray_data", rf_wdata, 32'h0);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
